// File: rtl/product_control.sv
// Sequential shift-add unsigned multiplier controller: IDLE -> LOAD -> CALC (WIDTH iterations) -> DONE.
// Run accepted only in IDLE; Ready pulses one cycle, WIDTH+2 cycles after Run is sampled.
module product_control #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 Run,
   input  logic [WIDTH-1:0]     Multiplier_in,
   input  logic [WIDTH-1:0]     Multiplicand_in,
   output logic                 Mcand_W_ctrl,
   output logic [2*WIDTH-1:0]   Product_out,
   output logic                 Busy,
   output logic                 Ready
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, ready_q, mcand_w_q;
   logic [WIDTH:0]       addend;
   logic [WIDTH:0]       sum;

   // The upper half plus the multiplicand keeps its carry, which is shifted into the top bit.
   assign addend = product_q[0] ? {1'b0, Multiplicand_in} : '0;
   assign sum    = {1'b0, product_q[2*WIDTH-1:WIDTH]} + addend;

   always_comb begin
      state_d   = state_q;
      product_d = product_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (Run) state_d = LOAD;
         end
         LOAD: begin
            product_d = {{WIDTH{1'b0}}, Multiplier_in};
            cnt_d     = '0;
            state_d   = CALC;
         end
         CALC: begin
            product_d = {sum, product_q[WIDTH-1:1]};
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered alongside the state so they reflect the state being entered.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         product_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         mcand_w_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         product_q <= product_d;
         cnt_q     <= cnt_d;
         busy_q    <= (state_d == LOAD) || (state_d == CALC);
         ready_q   <= (state_d == DONE);
         mcand_w_q <= (state_d == LOAD);
      end
   end

   assign Product_out  = product_q;
   assign Busy         = busy_q;
   assign Ready        = ready_q;
   assign Mcand_W_ctrl = mcand_w_q;

endmodule

// File: tb/tb_product_control.sv
// Directed bench for product_control with a behavioural Multiplicand register upstream.
module tb_product_control;

   logic          clk = 1'b0;
   logic          Reset;
   logic          Run;
   logic [31:0]   Multiplier_in;
   logic [31:0]   mcand_src;
   logic [31:0]   mcand_reg;
   logic          Mcand_W_ctrl;
   logic [63:0]   Product_out;
   logic          Busy;
   logic          Ready;

   int vectors     = 0;
   int miscompares = 0;

   product_control #(.WIDTH(32)) dut (
      .clk             (clk),
      .Reset           (Reset),
      .Run             (Run),
      .Multiplier_in   (Multiplier_in),
      .Multiplicand_in (mcand_reg),
      .Mcand_W_ctrl    (Mcand_W_ctrl),
      .Product_out     (Product_out),
      .Busy            (Busy),
      .Ready           (Ready)
   );

   always #5 clk = ~clk;

   // Upstream Multiplicand register, written only through the DUT's enable.
   always_ff @(posedge clk) begin
      if (Reset)             mcand_reg <= '0;
      else if (Mcand_W_ctrl) mcand_reg <= mcand_src;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_mul(input logic [31:0] mplr, input logic [31:0] mcnd,
                          input logic [63:0] exp, input string tag);
      int cyc, busy_n, wr_n;
      bit seen;
      cyc = 1; busy_n = 0; wr_n = 0; seen = 1'b0;
      Multiplier_in = mplr;
      mcand_src     = mcnd;
      Run = 1'b1;
      tick;
      Run = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (Ready) begin
            seen = 1'b1;
            break;
         end
         busy_n += int'(Busy);
         wr_n   += int'(Mcand_W_ctrl);
         // Operands move once CALC has started; the result must not notice.
         if (i == 1) begin
            Multiplier_in = ~mplr;
            mcand_src     = ~mcnd;
         end
         tick;
         cyc++;
      end
      check({tag, " ready_seen"},   64'(seen),   64'd1);
      check({tag, " latency"},      64'(cyc),    64'd34);
      check({tag, " busy_cycles"},  64'(busy_n), 64'd33);
      check({tag, " mcand_w_cyc"},  64'(wr_n),   64'd1);
      check({tag, " product"},      Product_out, exp);
      tick;
      check({tag, " ready_single"}, 64'(Ready),  64'd0);
      check({tag, " product_hold"}, Product_out, exp);
      check({tag, " idle_busy"},    64'(Busy),   64'd0);
   endtask

   initial begin
      int ready_n;
      logic [63:0] cap;

      Reset = 1'b1; Run = 1'b1; Multiplier_in = 32'hFFFF_FFFF; mcand_src = 32'hFFFF_FFFF;
      tick;
      tick;
      check("rst product", Product_out,          64'd0);
      check("rst busy",    64'(Busy),            64'd0);
      check("rst ready",   64'(Ready),           64'd0);
      check("rst mcand_w", 64'(Mcand_W_ctrl),    64'd0);
      Reset = 1'b0; Run = 1'b0;
      tick;

      run_mul(32'd5,          32'd3,          64'h0000_0000_0000_000F, "5x3");
      run_mul(32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, "max");
      run_mul(32'h0,          32'hDEAD_BEEF,  64'h0,                   "zero");
      run_mul(32'hDEAD_BEEF,  32'h1,          64'h0000_0000_DEAD_BEEF, "by_one");
      run_mul(32'h1234_5678,  32'h2,          64'h0000_0000_2468_ACF0, "by_two");

      // Run re-pulsed mid-CALC with new operands: 6*7 must complete untouched.
      ready_n = 0; cap = '0;
      Multiplier_in = 32'd6; mcand_src = 32'd7; Run = 1'b1;
      tick;
      Run = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (i == 11) begin
            Run = 1'b1; Multiplier_in = 32'd99; mcand_src = 32'd99;
         end
         if (i == 12) Run = 1'b0;
         if (Ready) begin
            ready_n++;
            cap = Product_out;
         end
         tick;
      end
      check("repulse ready_count", 64'(ready_n), 64'd1);
      check("repulse product",     cap,          64'd42);
      check("repulse not_queued",  64'(Busy),    64'd0);

      // Reset after 16 iterations aborts with no Ready.
      Multiplier_in = 32'hFFFF_FFFF; mcand_src = 32'hFFFF_FFFF; Run = 1'b1;
      tick;
      Run = 1'b0;
      tick;
      for (int i = 0; i < 16; i++) tick;
      Reset = 1'b1;
      tick;
      check("abort product", Product_out,       64'd0);
      check("abort busy",    64'(Busy),         64'd0);
      check("abort ready",   64'(Ready),        64'd0);
      check("abort mcand_w", 64'(Mcand_W_ctrl), 64'd0);
      Reset = 1'b0;
      ready_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (Ready) ready_n++;
         tick;
      end
      check("abort no_ready", 64'(ready_n), 64'd0);

      run_mul(32'd7, 32'd9, 64'h3F, "7x9");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
